// File: rtl/pod_pkg.sv
// Shared types and helpers for the pod-memory write-port arbiter.
package pod_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } arb_state_t;

  localparam int N_REQ_DEFAULT = 5;
  localparam int REQ_IDX_RING  = 4;
  localparam int RR_IDX_W      = $clog2(N_REQ_DEFAULT);

  // Reference round-robin pick for the default requester count: first valid
  // index at or after ptr, wrapping. Returns ptr when nothing is valid.
  function automatic logic [RR_IDX_W-1:0] rr_pick(
    input logic [N_REQ_DEFAULT-1:0] valid,
    input logic [RR_IDX_W-1:0]      ptr
  );
    logic [RR_IDX_W-1:0] pick;
    logic                found;
    int                  idx;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < N_REQ_DEFAULT; i++) begin
      idx = (int'(ptr) + i) % N_REQ_DEFAULT;
      if (!found && valid[idx]) begin
        pick  = RR_IDX_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_pick_n.sv
// Combinational round-robin picker: rotate the valid vector so the pointer
// sits at bit 0, priority-encode the lowest set bit, then rotate back.
module rr_pick_n #(
  parameter int N  = 5,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] pick,
  output logic          any_valid
);

  logic [2*N-1:0] doubled;
  logic [N-1:0]   rotated;
  logic [IW-1:0]  offset;
  logic [IW:0]    sum;

  // Rotate, find the first requester at or after ptr, and map it back to an index
  always_comb begin
    doubled = {valid, valid};
    rotated = N'(doubled >> ptr);
    offset  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rotated[i]) offset = IW'(i);
    end
    sum = {1'b0, ptr} + {1'b0, offset};
    if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
    pick      = sum[IW-1:0];
    any_valid = |valid;
  end

endmodule

// File: rtl/pod_wport_arbiter.sv
// Round-robin, burst-aware arbiter sharing one pod-memory BRAM write port.
// Whole bursts are granted up to MAX_BURST beats; one IDLE bubble separates
// grants. Accepted beats reach the BRAM port one cycle later.
module pod_wport_arbiter
  import pod_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEFAULT,
  parameter int D_W       = 64,
  parameter int ADDR_W    = 14,
  parameter int MAX_BURST = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ-1:0]           req_last,
  input  logic [N_REQ*ADDR_W-1:0]    req_addr,
  input  logic [N_REQ*D_W-1:0]       req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       mem_w_en,
  output logic [ADDR_W-1:0]          mem_w_addr,
  output logic [D_W-1:0]             mem_w_data,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy
);

  localparam int GW    = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic [GW-1:0]    rr_ptr;
  logic [GW-1:0]    rr_nxt;
  logic [CNT_W-1:0] beat_cnt;
  logic [GW-1:0]    pick;
  logic             any_valid;
  logic             accept;
  logic             leave;

  rr_pick_n #(
    .N  (N_REQ),
    .IW (GW)
  ) u_pick (
    .valid     (req_valid),
    .ptr       (rr_ptr),
    .pick      (pick),
    .any_valid (any_valid)
  );

  assign busy   = (state == ST_GRANT);
  assign rr_nxt = (grant_id == GW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

  // Next state, ready to the granted requester, and burst termination
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    leave     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_valid) state_nxt = ST_GRANT;
      end
      ST_GRANT: begin
        req_ready[grant_id] = 1'b1;
        accept = req_valid[grant_id];
        if (!accept || req_last[grant_id] || (beat_cnt == CNT_W'(MAX_BURST - 1))) begin
          leave     = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM state, granted requester, beat counter and round-robin pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      grant_id <= '0;
      beat_cnt <= '0;
      rr_ptr   <= '0;
    end else begin
      state <= state_nxt;
      if ((state == ST_IDLE) && any_valid) begin
        grant_id <= pick;
        beat_cnt <= '0;
      end else if (accept) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (leave) rr_ptr <= rr_nxt;
    end
  end

  // Register each accepted beat onto the BRAM write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_w_en   <= 1'b0;
      mem_w_addr <= '0;
      mem_w_data <= '0;
    end else begin
      mem_w_en <= accept;
      if (accept) begin
        mem_w_addr <= req_addr[int'(grant_id)*ADDR_W +: ADDR_W];
        mem_w_data <= req_data[int'(grant_id)*D_W +: D_W];
      end
    end
  end

endmodule

// File: tb/tb_pod_wport_arbiter.sv
// Scoreboard bench for pod_wport_arbiter: requester queues feed beats,
// expected BRAM writes are queued in hand-derived order and checked as they appear.
module tb_pod_wport_arbiter;

  localparam int N  = 5;
  localparam int AW = 14;
  localparam int DW = 64;
  localparam int MB = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_last;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              mem_w_en;
  logic [AW-1:0]     mem_w_addr;
  logic [DW-1:0]     mem_w_data;
  logic [2:0]        grant_id;
  logic              busy;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct {
    int            rid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            gap;
  } exp_t;

  beat_t src_q [N][$];
  exp_t  exp_q [$];
  int    vectors     = 0;
  int    miscompares = 0;
  int    cyc         = 0;
  int    last_wcyc   = 0;

  pod_wport_arbiter #(
    .N_REQ     (N),
    .D_W       (DW),
    .ADDR_W    (AW),
    .MAX_BURST (MB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .mem_w_en   (mem_w_en),
    .mem_w_addr (mem_w_addr),
    .mem_w_data (mem_w_data),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  // Free-running clock
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mkData(input int rid, input int tag, input int beat);
    return {8'(rid), 24'(tag), 32'(beat)};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Queue n beats for requester rid; last every burst_len beats, final beat's last given explicitly
  task automatic applyStimulus(input int rid, input int base, input int tag, input int first_beat,
                               input int n, input int burst_len, input logic final_last);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.addr = AW'(base + first_beat + k);
      b.data = mkData(rid, tag, first_beat + k);
      b.last = (k == n - 1) ? final_last : (((k + 1) % burst_len) == 0);
      src_q[rid].push_back(b);
    end
  endtask

  // Expected writes in arbitration order; gap 0 means the spacing is not checked
  task automatic expectBurst(input int rid, input int base, input int tag, input int first_beat,
                             input int n, input int first_gap);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.rid  = rid;
      e.addr = AW'(base + first_beat + k);
      e.data = mkData(rid, tag, first_beat + k);
      e.gap  = (k == 0) ? first_gap : 1;
      exp_q.push_back(e);
    end
  endtask

  task automatic flushAll();
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
  endtask

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_w_en"},  64'(mem_w_en),   64'd0);
    checkOutput({tag, "_busy"},  64'(busy),       64'd0);
    checkOutput({tag, "_gid"},   64'(grant_id),   64'd0);
    checkOutput({tag, "_ready"}, 64'(req_ready),  64'd0);
    checkOutput({tag, "_addr"},  64'(mem_w_addr), 64'd0);
    checkOutput({tag, "_data"},  64'(mem_w_data), 64'(0));
  endtask

  task automatic waitDrain(input string name);
    int  t;
    logic done;
    done = 1'b0;
    for (t = 0; t < 400 && !done; t++) begin
      @(posedge clk);
      done = (exp_q.size() == 0);
      for (int i = 0; i < N; i++) if (src_q[i].size() != 0) done = 1'b0;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s_drain: got %0d writes pending, want 0", name, exp_q.size());
      flushAll();
    end
    repeat (4) @(posedge clk);
  endtask

  // Requester model: pop beats accepted in the previous cycle, then present the next ones
  initial begin
    logic [N-1:0] acc;
    req_valid = '0;
    req_last  = '0;
    req_addr  = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      #2;
      for (int i = 0; i < N; i++) begin
        if (src_q[i].size() > 0) begin
          req_valid[i]           = 1'b1;
          req_last[i]            = src_q[i][0].last;
          req_addr[i*AW +: AW]   = src_q[i][0].addr;
          req_data[i*DW +: DW]   = src_q[i][0].data;
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
    end
  end

  // Monitor: every BRAM write must match the head of the expected queue
  initial begin
    exp_t e;
    int   gap;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst && mem_w_en) begin
        vectors++;
        gap = cyc - last_wcyc;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_write: got addr %h data %h gid %0d, want no write",
                   mem_w_addr, mem_w_data, grant_id);
        end else begin
          e = exp_q.pop_front();
          if (mem_w_addr !== e.addr || mem_w_data !== e.data || int'(grant_id) != e.rid ||
              (e.gap != 0 && gap != e.gap)) begin
            miscompares++;
            $display("[TB] FAIL write: got addr %h data %h gid %0d gap %0d, want addr %h data %h gid %0d gap %0d",
                     mem_w_addr, mem_w_data, grant_id, gap, e.addr, e.data, e.rid, e.gap);
          end
        end
        last_wcyc = cyc;
      end
    end
  end

  // Directed test sequence
  initial begin
    int  j;
    logic found;

    #3 rst = 1'b0;
    #1 checkResetState("por");
    repeat (2) sync();
    rst = 1'b1;

    // Single requester 2, three beats 0x10..0x12
    sync();
    expectBurst(2, 'h0F, 2, 1, 3, 0);
    applyStimulus(2, 'h0F, 2, 1, 3, 3, 1'b1);
    waitDrain("t2");
    checkOutput("t2_busy", 64'(busy), 64'd0);
    checkOutput("t2_gid", 64'(grant_id), 64'd2);

    // Pointer now 3: req 3 wins over req 0
    sync();
    expectBurst(3, 'h300, 21, 1, 1, 0);
    expectBurst(0, 'h200, 21, 1, 1, 2);
    applyStimulus(0, 'h200, 21, 1, 1, 1, 1'b1);
    applyStimulus(3, 'h300, 21, 1, 1, 1, 1'b1);
    waitDrain("t2b");

    // Reset in the middle of a 4-beat burst from req 1: only beat 1 reaches memory
    sync();
    expectBurst(1, 'h1F, 1, 1, 1, 0);
    applyStimulus(1, 'h1F, 1, 1, 4, 4, 1'b1);
    found = 1'b0;
    for (int t = 0; t < 50 && !found; t++) begin
      @(posedge clk);
      found = (exp_q.size() == 0);
    end
    checkOutput("t1_beat1_seen", 64'(found), 64'd1);
    #2 rst = 1'b0;
    flushAll();
    #1 checkResetState("t1");
    repeat (3) sync();
    rst = 1'b1;
    // Pointer back at 0: req 0 before req 4
    sync();
    expectBurst(0, 'h400, 11, 1, 1, 0);
    expectBurst(4, 'h440, 11, 1, 1, 2);
    applyStimulus(0, 'h400, 11, 1, 1, 1, 1'b1);
    applyStimulus(4, 'h440, 11, 1, 1, 1, 1'b1);
    waitDrain("t1");

    // Round-robin among 0,1,4 with single-beat bursts
    sync();
    for (int r = 1; r <= 2; r++) begin
      expectBurst(0, 'h500, 3, r, 1, (r == 1) ? 0 : 2);
      expectBurst(1, 'h520, 3, r, 1, 2);
      expectBurst(4, 'h540, 3, r, 1, 2);
    end
    applyStimulus(0, 'h500, 3, 1, 2, 1, 1'b1);
    applyStimulus(1, 'h520, 3, 1, 2, 1, 1'b1);
    applyStimulus(4, 'h540, 3, 1, 2, 1, 1'b1);
    waitDrain("t3");

    // Burst cap: req 3 sends 20 beats, req 0 joins one cycle later
    sync();
    expectBurst(3, 'h600, 4, 1, 8, 0);
    expectBurst(0, 'h680, 4, 1, 1, 2);
    expectBurst(3, 'h600, 4, 9, 8, 2);
    expectBurst(3, 'h600, 4, 17, 4, 2);
    applyStimulus(3, 'h600, 4, 1, 20, 20, 1'b1);
    sync();
    applyStimulus(0, 'h680, 4, 1, 1, 1, 1'b1);
    waitDrain("t4");

    // Stall release: req 1 stops after one non-last beat, req 2 follows
    sync();
    expectBurst(1, 'h700, 5, 1, 1, 0);
    expectBurst(2, 'h740, 5, 1, 1, 3);
    applyStimulus(1, 'h700, 5, 1, 1, 1, 1'b0);
    applyStimulus(2, 'h740, 5, 1, 1, 1, 1'b1);
    waitDrain("t5");

    // Move the pointer to 0 so req 4 is served last in the starvation case
    sync();
    expectBurst(4, 'h7C0, 8, 1, 1, 0);
    applyStimulus(4, 'h7C0, 8, 1, 1, 1, 1'b1);
    waitDrain("t6prep");

    // Starvation: all five requesters with full-length bursts
    sync();
    for (int r = 0; r < N; r++) begin
      expectBurst(r, 'h900 + r * 'h20, 7, 1, MB, (r == 0) ? 0 : 2);
      applyStimulus(r, 'h900 + r * 'h20, 7, 1, MB, MB, 1'b1);
    end
    j = 0;
    found = 1'b0;
    while (!found && j < 100) begin
      @(negedge clk);
      if (busy && grant_id == 3'd4) found = 1'b1;
      else j++;
    end
    vectors++;
    if (!found || j > (N - 1) * (MB + 1) + 1) begin
      miscompares++;
      $display("[TB] FAIL t6_starve: got %0d cycles, want <= %0d", j, (N - 1) * (MB + 1) + 1);
    end
    waitDrain("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
